// File: rtl/eth_rx_frame_buffer.sv
// Ping-pong receive buffer: MAC bytes in, two committed frames held for the CPU; optional ETH_RX_DROP_COUNT_EN drop counter.
// Latency: ready one cycle after the last byte, rdata one cycle after raddr; no backpressure, frames arriving with no free bank are dropped.
module eth_rx_frame_buffer #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_sof,
    input  logic              rx_last,
    input  logic              rx_err,
    input  logic [ADDR_W-1:0] eth_rx_raddr,
    output logic [7:0]        eth_rx_rdata,
    output logic              eth_rx_ready,
    input  logic              eth_rx_read,
    output logic [ADDR_W:0]   eth_rx_len,
    output logic [7:0]        eth_rx_drops
);

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} wstate_t;

    wstate_t           state, state_nxt;
    logic [ADDR_W:0]   wptr, wptr_nxt;
    logic [ADDR_W-1:0] waddr;
    logic              we, end_frame, commit, drop;
    logic              wbank, rbank;
    logic [1:0]        count, count_nxt;
    logic              read_q, rel_go;
    logic [ADDR_W:0]   len_mem [0:1];
    logic [7:0]        mem [0:(2**(ADDR_W+1))-1];

    always_comb begin
        state_nxt = state;
        wptr_nxt  = wptr;
        waddr     = '0;
        we        = 1'b0;
        end_frame = 1'b0;
        drop      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE, DISCARD: begin
                if (rx_valid && rx_sof) begin
                    if (count != 2'd2) begin
                        we        = 1'b1;
                        wptr_nxt  = {{ADDR_W{1'b0}}, 1'b1};
                        end_frame = rx_last;
                        state_nxt = RECV;
                    end else begin
                        drop      = 1'b1;
                        state_nxt = rx_last ? IDLE : DISCARD;
                    end
                end else if (state == DISCARD && rx_valid && rx_last) begin
                    state_nxt = IDLE;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    if (rx_sof) begin
                        // Restart in the same bank; the aborted partial frame is not a drop.
                        we        = 1'b1;
                        wptr_nxt  = {{ADDR_W{1'b0}}, 1'b1};
                        end_frame = rx_last;
                    end else if (wptr == FULL) begin
                        drop      = 1'b1;
                        state_nxt = rx_last ? IDLE : DISCARD;
                    end else begin
                        we        = 1'b1;
                        waddr     = wptr[ADDR_W-1:0];
                        wptr_nxt  = wptr + 1'b1;
                        end_frame = rx_last;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (end_frame) begin
            state_nxt = IDLE;
            if (rx_err) drop   = 1'b1;
            else        commit = 1'b1;
        end
    end

    assign rel_go = eth_rx_read && !read_q && (count != 2'd0);

    always_comb begin
        count_nxt = count;
        if (commit && !rel_go)      count_nxt = count + 2'd1;
        else if (!commit && rel_go) count_nxt = count - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wptr         <= '0;
            wbank        <= 1'b0;
            rbank        <= 1'b0;
            count        <= 2'd0;
            read_q       <= 1'b0;
            eth_rx_ready <= 1'b0;
            eth_rx_rdata <= 8'd0;
            len_mem[0]   <= '0;
            len_mem[1]   <= '0;
        end else begin
            state        <= state_nxt;
            wptr         <= wptr_nxt;
            count        <= count_nxt;
            read_q       <= eth_rx_read;
            eth_rx_ready <= (count_nxt != 2'd0);
            eth_rx_rdata <= mem[{rbank, eth_rx_raddr}];
            if (commit) begin
                len_mem[wbank] <= wptr_nxt;
                wbank          <= ~wbank;
            end
            if (rel_go) rbank <= ~rbank;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[{wbank, waddr}] <= rx_data;
    end

    assign eth_rx_len = (count == 2'd0) ? '0 : len_mem[rbank];

`ifdef ETH_RX_DROP_COUNT_EN
    logic [7:0] drops;

    always_ff @(posedge clk) begin
        if (reset)                       drops <= 8'd0;
        else if (drop && drops != 8'hFF) drops <= drops + 8'd1;
    end

    assign eth_rx_drops = drops;
`else
    logic unused_drop;
    assign unused_drop  = drop;
    assign eth_rx_drops = 8'd0;
`endif

endmodule
